// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode-to-execute pipeline register feeding the ALU. Resolves
//            EX/MEM and MEM/WB operand forwarding at capture, selects the
//            immediate operand, and holds one instruction under a valid/ready
//            handshake with stall, flush and hold-time MEM/WB refresh.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_alusrc,
   input  logic [1:0]      id_aluctr,
   input  logic            id_regwrite,
   input  logic            exm_we,
   input  logic [REGW-1:0] exm_rd,
   input  logic [XLEN-1:0] exm_data,
   input  logic            mwb_we,
   input  logic [REGW-1:0] mwb_rd,
   input  logic [XLEN-1:0] mwb_data,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] aluin1,
   output logic [XLEN-1:0] aluin2,
   output logic [1:0]      aluctr,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_regwrite,
   output logic [XLEN-1:0] ex_store_data
);

   // ALU operation encodings shared with the ALU
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            capture;
   logic            hold;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic            regwrite_q;
   logic [REGW-1:0] held_rs1;
   logic [REGW-1:0] held_rs2;
   logic            held_alusrc;
   logic            refresh_rs1;
   logic            refresh_rs2;

   assign ex_valid    = (state == S_FULL);
   assign id_ready    = !rst && (!ex_valid || ex_ready);
   assign capture     = id_valid && id_ready && !flush;
   assign hold        = ex_valid && !ex_ready;
   assign ex_regwrite = ex_valid && regwrite_q;

   // Only MEM/WB can still produce a newer value while the instruction waits;
   // register 0 is hard-wired and never refreshed.
   assign refresh_rs1 = mwb_we && (mwb_rd == held_rs1) && (held_rs1 != '0);
   assign refresh_rs2 = mwb_we && (mwb_rd == held_rs2) && (held_rs2 != '0);

   // Operand forwarding at capture: EX/MEM beats MEM/WB beats register file
   always_comb begin
      fwd_rs1 = id_rs1_data;
      fwd_rs2 = id_rs2_data;
      if (exm_we && (exm_rd == id_rs1) && (id_rs1 != '0))
         fwd_rs1 = exm_data;
      else if (mwb_we && (mwb_rd == id_rs1) && (id_rs1 != '0))
         fwd_rs1 = mwb_data;
      if (exm_we && (exm_rd == id_rs2) && (id_rs2 != '0))
         fwd_rs2 = exm_data;
      else if (mwb_we && (mwb_rd == id_rs2) && (id_rs2 != '0))
         fwd_rs2 = mwb_data;
   end

   // Occupancy next-state: flush always empties, otherwise capture refills
   always_comb begin
      state_next = state;
      case (state)
         S_EMPTY: begin
            if (capture)
               state_next = S_FULL;
         end
         S_FULL: begin
            if (flush)
               state_next = S_EMPTY;
            else if (ex_ready)
               state_next = capture ? S_FULL : S_EMPTY;
         end
         default: state_next = S_EMPTY;
      endcase
   end

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_EMPTY;
      else
         state <= state_next;
   end

   // Payload register: load on capture, refresh from MEM/WB while held
   always_ff @(posedge clk) begin
      if (rst) begin
         aluin1        <= '0;
         aluin2        <= '0;
         ex_store_data <= '0;
         aluctr        <= ALU_ADD;
         ex_rd         <= '0;
         regwrite_q    <= 1'b0;
         held_rs1      <= '0;
         held_rs2      <= '0;
         held_alusrc   <= 1'b0;
      end else if (capture) begin
         aluin1        <= fwd_rs1;
         aluin2        <= id_alusrc ? id_imm : fwd_rs2;
         ex_store_data <= fwd_rs2;
         aluctr        <= id_aluctr;
         ex_rd         <= id_rd;
         regwrite_q    <= id_regwrite;
         held_rs1      <= id_rs1;
         held_rs2      <= id_rs2;
         held_alusrc   <= id_alusrc;
      end else if (hold) begin
         if (refresh_rs1)
            aluin1 <= mwb_data;
         if (refresh_rs2) begin
            ex_store_data <= mwb_data;
            if (!held_alusrc)
               aluin2 <= mwb_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly upstream of the ALU; produces registered aluin1, aluin2 and aluctr for it.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects the immediate vs. register operand.
- Holds one instruction under a valid/ready handshake, with stall and flush support.

Parameters:
- XLEN, 32, datapath width; must match the ALU operand width.
- REGW, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  decode presents an instruction.
- id_ready  output  1  stage can accept this cycle.
- id_rs1_data  input  XLEN  register-file read value for rs1.
- id_rs2_data  input  XLEN  register-file read value for rs2.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1  input  REGW  rs1 index.
- id_rs2  input  REGW  rs2 index.
- id_rd  input  REGW  destination index.
- id_alusrc  input  1  1 = aluin2 takes the immediate.
- id_aluctr  input  2  ALU operation code (`ALU_ADD/`ALU_SUB/`ALU_AND/`ALU_OR from def.sv).
- id_regwrite  input  1  instruction writes rd.
- exm_we  input  1  EX/MEM stage writes a register.
- exm_rd  input  REGW  EX/MEM destination.
- exm_data  input  XLEN  EX/MEM result.
- mwb_we  input  1  MEM/WB stage writes a register.
- mwb_rd  input  REGW  MEM/WB destination.
- mwb_data  input  XLEN  MEM/WB write-back value.
- flush  input  1  kill the held instruction (branch/exception).
- ex_ready  input  1  ALU consumer accepts this cycle.
- ex_valid  output  1  aluin1/aluin2/aluctr hold a live instruction.
- aluin1  output  XLEN  ALU operand 1.
- aluin2  output  XLEN  ALU operand 2.
- aluctr  output  2  ALU operation.
- ex_rd  output  REGW  destination index.
- ex_regwrite  output  1  write-enable, qualified by ex_valid.
- ex_store_data  output  XLEN  forwarded rs2 value, always, regardless of alusrc.

Behaviour:
- Reset, synchronous on rst=1:
  - ex_valid=0, aluin1=0, aluin2=0, ex_store_data=0, ex_rd=0, ex_regwrite=0.
  - aluctr=`ALU_ADD.
  - Internal held rs1/rs2/alusrc state cleared.
  - rst overrides flush and capture. id_ready is 0 during rst=1 and 1 on the first cycle after.
- Handshake:
  - id_ready = !ex_valid | ex_ready, combinational; does not depend on id_valid.
  - Capture occurs when id_valid & id_ready & !flush. All outputs are registered, so latency is 1 cycle.
  - Transfer out occurs when ex_valid & ex_ready.
  - With ex_valid=1 and ex_ready=0 (HOLD), all outputs stay stable apart from the MEM/WB refresh below.
- States:
  - EMPTY (ex_valid=0): capture goes to FULL; otherwise stay.
  - FULL (ex_valid=1):
    - ex_ready=1 with capture: stay FULL with the new instruction (back-to-back, no bubble).
    - ex_ready=1 without capture: go to EMPTY.
    - ex_ready=0: HOLD.
- Flush:
  - Next cycle ex_valid=0 and ex_regwrite=0.
  - The incoming instruction is discarded even if id_valid=1; id_ready is unaffected.
  - Data outputs may keep stale values and are don't-care while ex_valid=0.
- Forwarding at capture, per source operand s ∈ {rs1, rs2}:
  - If exm_we & exm_rd==s & s!=0: use exm_data.
  - Else if mwb_we & mwb_rd==s & s!=0: use mwb_data.
  - Else: use the id_*_data register-file value.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded, i.e. the value passes through from id_*_data.
  - Output mapping:
    - aluin1 = fwd(rs1).
    - aluin2 = id_alusrc ? id_imm : fwd(rs2).
    - ex_store_data = fwd(rs2).
- HOLD refresh:
  - Each HOLD cycle, if mwb_we & mwb_rd==held rs1 & held rs1!=0, aluin1 ← mwb_data.
  - Likewise for rs2: update ex_store_data, and aluin2 only if held alusrc==0.
  - EX/MEM is not consulted during HOLD.
- Hazards: load-use hazards are resolved upstream by the decoder; this stage performs no interlock.
- ex_regwrite is captured from id_regwrite and forced to 0 whenever ex_valid=0.
- Data paths carry no arithmetic, so widths pass through unchanged.

Test Plan:
- Reset and pass-through:
  - Stimulus: rst 2 cycles, then id_valid=1, rs1=3 (data 0x10), rs2=4 (data 0x20), alusrc=0, aluctr=`ALU_SUB, ex_ready=1.
  - Response: next cycle ex_valid=1, aluin1=0x10, aluin2=0x20, aluctr=`ALU_SUB. Immediately after reset: all outputs 0 and aluctr=`ALU_ADD.
- Forward priority:
  - Stimulus: rs1=5 with exm_we=1, exm_rd=5, exm_data=0xAAAA and mwb_we=1, mwb_rd=5, mwb_data=0xBBBB.
  - Response: aluin1=0xAAAA. Repeating with exm_we=0 gives 0xBBBB. Repeating with rs1=0, exm_rd=0 gives the raw id_rs1_data.
- Immediate select:
  - Stimulus: alusrc=1, imm=0xFFFFFFFC, rs2=6 forwarded from exm with 0x55.
  - Response: aluin2=0xFFFFFFFC, ex_store_data=0x55.
- Stall and hold refresh:
  - Stimulus: capture rs1=7, then hold ex_ready=0 for 3 cycles; in cycle 2 pulse mwb_we=1, mwb_rd=7, mwb_data=0x1234.
  - Response:
    - id_ready=0 throughout the hold.
    - aluin1 becomes 0x1234 one cycle after the pulse; all other outputs stable.
    - A new id_valid is not accepted until ex_ready=1.
- Back-to-back and flush:
  - Stimulus: ex_ready=1, id_valid=1 for 4 consecutive instructions.
  - Response:
    - One instruction per cycle with ex_valid continuous.
    - Asserting flush in cycle 3 gives ex_valid=0 and ex_regwrite=0 in cycle 4; the cycle-3 instruction never appears.
- Reset mid-operation:
  - Stimulus: FULL with ex_ready=0, then rst=1 together with id_valid=1 and flush=0.
  - Response: next cycle ex_valid=0 and all outputs at their reset values.
